// File: rtl/blake2b_msg_sched.sv
// BLAKE2b message scheduler: buffers one 16-word block and streams it in SIGMA order for ROUNDS rounds.
// Define MSG_SCHED_DBUF_EN for a second bank so the next block loads while the current one streams.
module blake2b_msg_sched #(
  parameter int WORD_W = 64,
  parameter int ROUNDS = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m_valid_i,
  output logic              m_ready_o,
  input  logic [WORD_W-1:0] m_data_i,
  output logic              w_valid_o,
  input  logic              w_ready_i,
  output logic [WORD_W-1:0] w_data_o,
  output logic [3:0]        w_round_o,
  output logic [3:0]        w_col_o,
  output logic              w_last_o,
  output logic              busy_o
);

  typedef enum logic {S_LOAD, S_STREAM} state_t;

  state_t     state, state_nxt;
  logic [4:0] ld_cnt;
  logic [3:0] rnd, col, row, sig;
  logic       m_xfer, w_xfer, ld_done, idle_full, swap;

  // Each row packs SIGMA[row][c] in nibble c (column 0 in the low nibble).
  function automatic logic [63:0] sigma_row(input logic [3:0] r);
    case (r)
      4'd1:    return 64'h357B20C16DF984AE;
      4'd2:    return 64'h491763EADF250C8B;
      4'd3:    return 64'h8F04A562EBCD1397;
      4'd4:    return 64'hD386CB1EFA427509;
      4'd5:    return 64'h91EF57D438B0A6C2;
      4'd6:    return 64'hB8293670A4DEF15C;
      4'd7:    return 64'hA2684F05931CE7BD;
      4'd8:    return 64'h5A417D2C803B9EF6;
      4'd9:    return 64'h0DC3E9BF5167482A;
      default: return 64'hFEDCBA9876543210;
    endcase
  endfunction

  // r never exceeds 15, so one conditional subtract implements r mod 10.
  assign row = (rnd >= 4'd10) ? rnd - 4'd10 : rnd;
  assign sig = sigma_row(row)[{col, 2'b00} +: 4];

  assign m_xfer  = m_valid_i & m_ready_o;
  assign w_xfer  = w_valid_o & w_ready_i;
  assign ld_done = m_xfer && (ld_cnt == 5'd15);

`ifdef MSG_SCHED_DBUF_EN
  logic              wr_bank, rd_bank;
  logic [WORD_W-1:0] mem [32];
  logic [4:0]        wr_addr, rd_addr;
  assign wr_addr   = {wr_bank, ld_cnt[3:0]};
  assign rd_addr   = {rd_bank, sig};
  // A load completing in the same cycle as the last stream word still counts as full.
  assign idle_full = ld_cnt[4] | ld_done;
`else
  logic [WORD_W-1:0] mem [16];
  logic [3:0]        wr_addr, rd_addr;
  assign wr_addr   = ld_cnt[3:0];
  assign rd_addr   = sig;
  assign idle_full = 1'b0;
`endif

  assign swap = ((state == S_LOAD) && ld_done) || (w_xfer && w_last_o && idle_full);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= S_LOAD;
      ld_cnt <= '0;
      rnd    <= '0;
      col    <= '0;
`ifdef MSG_SCHED_DBUF_EN
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (swap)        ld_cnt <= '0;
      else if (m_xfer) ld_cnt <= ld_cnt + 5'd1;
      if (w_xfer) begin
        col <= col + 4'd1;
        if (col == 4'd15) rnd <= w_last_o ? 4'd0 : rnd + 4'd1;
      end
`ifdef MSG_SCHED_DBUF_EN
      if (swap) begin
        rd_bank <= wr_bank;
        wr_bank <= ~wr_bank;
      end
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (m_xfer) mem[wr_addr] <= m_data_i;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:   if (ld_done) state_nxt = S_STREAM;
      S_STREAM: if (w_xfer && w_last_o) state_nxt = idle_full ? S_STREAM : S_LOAD;
      default:  state_nxt = S_LOAD;
    endcase
  end

  always_comb begin
    m_ready_o = 1'b0;
    w_valid_o = 1'b0;
    case (state)
      S_LOAD:   m_ready_o = 1'b1;
      S_STREAM: begin
        w_valid_o = 1'b1;
`ifdef MSG_SCHED_DBUF_EN
        m_ready_o = ~ld_cnt[4];
`endif
      end
      default: ;
    endcase
    w_last_o  = w_valid_o && (rnd == 4'(ROUNDS - 1)) && (col == 4'd15);
    w_round_o = rnd;
    w_col_o   = col;
    w_data_o  = mem[rd_addr];
    busy_o    = (state != S_LOAD) || (ld_cnt != 5'd0);
  end

endmodule

// File: tb/tb_blake2b_msg_sched.sv
// Bench for blake2b_msg_sched: fixed vectors, backpressure, mid-stream reset and randomized blocks vs a SIGMA model.
module tb_blake2b_msg_sched;
  localparam int W  = 64;
  localparam int R  = 12;
  localparam int NW = 16 * R;

  logic         clk = 1'b0;
  logic         rst, m_valid, m_ready, w_valid, w_ready, w_last, busy;
  logic [W-1:0] m_data, w_data;
  logic [3:0]   w_round, w_col;

  always #5 clk = ~clk;

  blake2b_msg_sched #(.WORD_W(W), .ROUNDS(R)) dut (
    .clk_i(clk), .rst_i(rst),
    .m_valid_i(m_valid), .m_ready_o(m_ready), .m_data_i(m_data),
    .w_valid_o(w_valid), .w_ready_i(w_ready), .w_data_o(w_data),
    .w_round_o(w_round), .w_col_o(w_col), .w_last_o(w_last), .busy_o(busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  int bg_k  = 0;

  int sigma [10][16] = '{
    '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
    '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
    '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
    '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
    '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
    '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
    '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
    '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
    '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
    '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}
  };

  logic [W-1:0] m   [16];
  logic [W-1:0] mb  [16];
  logic [W-1:0] got [NW];

  typedef struct { int r; int c; logic [W-1:0] exp; } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stream position n is round n/16, column n%16, carrying m[SIGMA[round mod 10][column]].
  function automatic logic [W-1:0] model(input int n);
    return m[sigma[(n / 16) % 10][n % 16]];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_block();
    for (int k = 0; k < 16; k++) m[k] = {$urandom, $urandom};
  endtask

  task automatic load_blk(input bit gaps);
    int k = 0;
    int cyc = 0;
    while (k < 16 && cyc < 200) begin
      m_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      m_data  = m[k];
      if (m_valid && m_ready) k++;
      tick();
      cyc++;
    end
    m_valid = 1'b0;
    if (k < 16) chk("load_timeout", 64'(k), 64'd16);
  endtask

  // Performs transfers from..to-1 and returns with word 'to' presented but not taken.
  task automatic run_stream(input int from, input int to, input int rdy_pct, input bit bg);
    int n = from;
    int cyc = 0;
    while (n < to && cyc < 4000) begin
      w_ready = ($urandom_range(1, 100) <= rdy_pct);
      if (bg) begin
        m_valid = (bg_k < 16);
        m_data  = mb[(bg_k < 16) ? bg_k : 0];
        if (m_valid && m_ready) bg_k++;
      end
      if (w_valid && w_ready) begin
        chk("data",  w_data, model(n));
        chk("round", 64'(w_round), 64'(n / 16));
        chk("col",   64'(w_col),   64'(n % 16));
        chk("last",  64'(w_last),  64'(n == NW - 1));
        got[n] = w_data;
        n++;
      end
      tick();
      cyc++;
    end
    w_ready = 1'b0;
    if (bg) m_valid = 1'b0;
    if (n < to) chk("stream_timeout", 64'(n), 64'(to));
  endtask

  initial begin
    rst = 1'b1; m_valid = 1'b0; w_ready = 1'b0; m_data = '0;
    tbl = '{
      '{ 0,  0, 64'h100}, '{ 0, 15, 64'h10F}, '{ 1,  0, 64'h10E}, '{ 1,  1, 64'h10A},
      '{10,  0, 64'h100}, '{11,  1, 64'h10A}, '{ 9,  0, 64'h10A}, '{ 9,  1, 64'h102},
      '{ 9,  2, 64'h108}, '{ 9,  3, 64'h104}, '{ 3,  7, 64'h10E}, '{11, 15, 64'h103}
    };
    tick(); tick();
    rst = 1'b0;
    chk("rst_m_ready", 64'(m_ready), 64'd1);
    chk("rst_w_valid", 64'(w_valid), 64'd0);
    chk("rst_round",   64'(w_round), 64'd0);
    chk("rst_col",     64'(w_col),   64'd0);
    chk("rst_last",    64'(w_last),  64'd0);
    chk("rst_busy",    64'(busy),    64'd0);

    // Basic ordered block, full-rate stream, then spot vectors.
    for (int k = 0; k < 16; k++) m[k] = 64'h100 + 64'(k);
    load_blk(1'b0);
    chk("first_valid", 64'(w_valid), 64'd1);
    chk("stream_busy", 64'(busy),    64'd1);
    chk("stream_no_ready", 64'(m_ready), 64'd0);
    run_stream(0, NW, 100, 1'b0);
    chk("end_w_valid", 64'(w_valid), 64'd0);
    chk("end_m_ready", 64'(m_ready), 64'd1);
    chk("end_busy",    64'(busy),    64'd0);
    for (int i = 0; i < 12; i++)
      chk($sformatf("vec_r%0d_c%0d", tbl[i].r, tbl[i].c), got[tbl[i].r * 16 + tbl[i].c], tbl[i].exp);

    // Randomized blocks with load gaps and random backpressure.
    for (int b = 0; b < 3; b++) begin
      rand_block();
      load_blk(1'b1);
      run_stream(0, NW, 60, 1'b0);
    end

    // Hold at r=3, c=7 for five cycles.
    rand_block();
    load_blk(1'b0);
    run_stream(0, 3 * 16 + 7, 100, 1'b0);
    for (int i = 0; i < 5; i++) begin
      w_ready = 1'b0;
      chk("hold_valid", 64'(w_valid), 64'd1);
      chk("hold_data",  w_data, m[14]);
      chk("hold_round", 64'(w_round), 64'd3);
      chk("hold_col",   64'(w_col),   64'd7);
      tick();
    end
    run_stream(3 * 16 + 7, NW, 100, 1'b0);

    // Reset at r=2, c=5 discards the block.
    rand_block();
    load_blk(1'b0);
    run_stream(0, 2 * 16 + 5, 100, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_w_valid", 64'(w_valid), 64'd0);
    chk("mrst_m_ready", 64'(m_ready), 64'd1);
    chk("mrst_busy",    64'(busy),    64'd0);
    chk("mrst_round",   64'(w_round), 64'd0);
    chk("mrst_col",     64'(w_col),   64'd0);
    rand_block();
    load_blk(1'b1);
    run_stream(0, NW, 80, 1'b0);

`ifdef MSG_SCHED_DBUF_EN
    // Block B loads while block A streams; B must follow with no bubble.
    rand_block();
    for (int k = 0; k < 16; k++) mb[k] = {$urandom, $urandom};
    load_blk(1'b0);
    bg_k = 0;
    run_stream(0, NW, 100, 1'b1);
    chk("dbuf_loaded",   64'(bg_k),    64'd16);
    chk("dbuf_nobubble", 64'(w_valid), 64'd1);
    m = mb;
    run_stream(0, NW, 100, 1'b0);
    chk("dbuf_end_valid", 64'(w_valid), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
